// File: rtl/elevator_scan_ctrl_if.sv
// Button/LED and car-status bundle between the switch fabric, the SCAN
// elevator controller and the floor/door display logic.
interface elevator_scan_ctrl_if #(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W    = 2
);
  logic [NUM_FLOORS-1:0] hall_up_req;
  logic [NUM_FLOORS-1:0] hall_dn_req;
  logic [NUM_FLOORS-1:0] car_req;
  logic                  door_hold;
  logic [NUM_FLOORS-1:0] hall_up_led;
  logic [NUM_FLOORS-1:0] hall_dn_led;
  logic [NUM_FLOORS-1:0] car_led;
  logic [FLOOR_W-1:0]    floor;
  logic [1:0]            direction;
  logic                  door_open;
  logic                  moving;

  modport master (
    output hall_up_req, hall_dn_req, car_req, door_hold,
    input  hall_up_led, hall_dn_led, car_led, floor, direction, door_open, moving
  );

  modport slave (
    input  hall_up_req, hall_dn_req, car_req, door_hold,
    output hall_up_led, hall_dn_led, car_led, floor, direction, door_open, moving
  );
endinterface

// File: rtl/elevator_scan_ctrl.sv
// Single-car SCAN elevator controller: latches hall/car requests, moves one
// floor per MOVE_CYCLES and holds the door open for DOOR_CYCLES.
module elevator_scan_ctrl #(
  parameter int NUM_FLOORS  = 4,
  parameter int FLOOR_W     = 2,
  parameter int MOVE_CYCLES = 8,
  parameter int DOOR_CYCLES = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  elevator_scan_ctrl_if.slave  bus
);

  localparam int MW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [MW-1:0]         MOVE_LOAD = MW'(MOVE_CYCLES - 1);
  localparam logic [DW-1:0]         DOOR_LOAD = DW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0]    TOP       = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [NUM_FLOORS-1:0] UP_VALID  = {NUM_FLOORS{1'b1}} >> 1;
  localparam logic [NUM_FLOORS-1:0] DN_VALID  = {NUM_FLOORS{1'b1}} << 1;
  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b10;
  localparam logic [1:0] DIR_DN   = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

  state_t                state;
  logic [FLOOR_W-1:0]    floor_q;
  logic [1:0]            dir_q;
  logic                  door_q;
  logic                  moving_q;
  logic [NUM_FLOORS-1:0] up_l, dn_l, car_l;
  logic [MW-1:0]         mv_cnt;
  logic [DW-1:0]         dr_cnt;

  logic [NUM_FLOORS-1:0] pend;
  logic                  pend_above, pend_below;
  logic [FLOOR_W-1:0]    nxt_floor;
  logic                  nxt_beyond, stop_here;
  logic                  cur_ahead, cur_behind, opp_latch;
  logic                  match_press, restart;
  logic                  mv_exp, dr_exp;
  logic                  idle_svc, move_svc, reopen;
  logic [FLOOR_W-1:0]    svc_floor;
  logic [1:0]            svc_dir;
  logic                  svc_beyond;
  logic [NUM_FLOORS-1:0] up_set, dn_set, car_set;
  logic [NUM_FLOORS-1:0] up_clr, dn_clr, car_clr;
  logic [NUM_FLOORS-1:0] up_nx, dn_nx, car_nx;

  function automatic logic any_above(input logic [NUM_FLOORS-1:0] p,
                                     input logic [FLOOR_W-1:0]    f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (i > int'(f)) r = r | p[i];
    return r;
  endfunction

  function automatic logic any_below(input logic [NUM_FLOORS-1:0] p,
                                     input logic [FLOOR_W-1:0]    f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (i < int'(f)) r = r | p[i];
    return r;
  endfunction

  function automatic logic [1:0] dir_rev(input logic [1:0] d);
    return {d[0], d[1]};
  endfunction

  always_comb begin
    pend       = up_l | dn_l | car_l;
    pend_above = any_above(pend, floor_q);
    pend_below = any_below(pend, floor_q);

    // Saturating step keeps the car inside 0..TOP whatever the direction says.
    if (dir_q == DIR_UP && floor_q != TOP)      nxt_floor = floor_q + 1'b1;
    else if (dir_q == DIR_DN && floor_q != '0)  nxt_floor = floor_q - 1'b1;
    else                                        nxt_floor = floor_q;

    nxt_beyond = (dir_q == DIR_UP) ? any_above(pend, nxt_floor) : any_below(pend, nxt_floor);
    stop_here  = car_l[nxt_floor]
               | ((dir_q == DIR_UP) ? up_l[nxt_floor] : dn_l[nxt_floor])
               | ~nxt_beyond;

    cur_ahead  = (dir_q == DIR_UP) ? pend_above : (dir_q == DIR_DN) ? pend_below : 1'b0;
    cur_behind = (dir_q == DIR_UP) ? pend_below : (dir_q == DIR_DN) ? pend_above : 1'b0;
    opp_latch  = (dir_q == DIR_UP) ? dn_l[floor_q] : (dir_q == DIR_DN) ? up_l[floor_q] : 1'b0;

    match_press = bus.car_req[floor_q]
                | ((dir_q != DIR_DN) & bus.hall_up_req[floor_q] & UP_VALID[floor_q])
                | ((dir_q != DIR_UP) & bus.hall_dn_req[floor_q] & DN_VALID[floor_q]);
    restart  = (state == S_DOOR) & (match_press | bus.door_hold);
    mv_exp   = (state == S_MOVE) & (mv_cnt == '0);
    dr_exp   = (state == S_DOOR) & ~restart & (dr_cnt == '0);
    idle_svc = (state == S_IDLE) & pend[floor_q];
    move_svc = mv_exp & stop_here;
    reopen   = dr_exp & ~cur_ahead & opp_latch;

    // A press that already matches the open door only retriggers the timer.
    car_set = bus.car_req;
    up_set  = bus.hall_up_req & UP_VALID;
    dn_set  = bus.hall_dn_req & DN_VALID;
    if (state == S_DOOR) begin
      car_set[floor_q] = 1'b0;
      if (dir_q != DIR_DN) up_set[floor_q] = 1'b0;
      if (dir_q != DIR_UP) dn_set[floor_q] = 1'b0;
    end

    svc_floor  = move_svc ? nxt_floor : floor_q;
    svc_dir    = move_svc ? dir_q : (reopen ? dir_rev(dir_q) : DIR_IDLE);
    svc_beyond = move_svc ? nxt_beyond : (reopen ? cur_behind : 1'b0);
    car_clr = '0;
    up_clr  = '0;
    dn_clr  = '0;
    if (idle_svc | move_svc | reopen) begin
      car_clr[svc_floor] = 1'b1;
      up_clr[svc_floor]  = (svc_dir != DIR_DN) | ~svc_beyond;
      dn_clr[svc_floor]  = (svc_dir != DIR_UP) | ~svc_beyond;
    end
    car_nx = (car_l | car_set) & ~car_clr;
    up_nx  = (up_l  | up_set)  & ~up_clr;
    dn_nx  = (dn_l  | dn_set)  & ~dn_clr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      floor_q  <= '0;
      dir_q    <= DIR_IDLE;
      door_q   <= 1'b0;
      moving_q <= 1'b0;
      up_l     <= '0;
      dn_l     <= '0;
      car_l    <= '0;
      mv_cnt   <= '0;
      dr_cnt   <= '0;
    end else begin
      up_l  <= up_nx;
      dn_l  <= dn_nx;
      car_l <= car_nx;
      unique case (state)
        S_IDLE: begin
          if (idle_svc) begin
            state  <= S_DOOR;
            door_q <= 1'b1;
            dr_cnt <= DOOR_LOAD;
          end else if (pend_above) begin
            dir_q    <= DIR_UP;
            state    <= S_MOVE;
            moving_q <= 1'b1;
            mv_cnt   <= MOVE_LOAD;
          end else if (pend_below) begin
            dir_q    <= DIR_DN;
            state    <= S_MOVE;
            moving_q <= 1'b1;
            mv_cnt   <= MOVE_LOAD;
          end
        end
        S_MOVE: begin
          if (!mv_exp) begin
            mv_cnt <= mv_cnt - 1'b1;
          end else begin
            floor_q <= nxt_floor;
            if (stop_here) begin
              state    <= S_DOOR;
              moving_q <= 1'b0;
              door_q   <= 1'b1;
              dr_cnt   <= DOOR_LOAD;
            end else begin
              mv_cnt <= MOVE_LOAD;
            end
          end
        end
        S_DOOR: begin
          if (restart) begin
            dr_cnt <= DOOR_LOAD;
          end else if (!dr_exp) begin
            dr_cnt <= dr_cnt - 1'b1;
          end else if (cur_ahead) begin
            state    <= S_MOVE;
            door_q   <= 1'b0;
            moving_q <= 1'b1;
            mv_cnt   <= MOVE_LOAD;
          end else if (opp_latch) begin
            // Door stays open and serves the opposite hall call before leaving.
            dir_q  <= dir_rev(dir_q);
            dr_cnt <= DOOR_LOAD;
          end else if (cur_behind) begin
            dir_q    <= dir_rev(dir_q);
            state    <= S_MOVE;
            door_q   <= 1'b0;
            moving_q <= 1'b1;
            mv_cnt   <= MOVE_LOAD;
          end else begin
            dir_q  <= DIR_IDLE;
            state  <= S_IDLE;
            door_q <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.hall_up_led = up_l;
  assign bus.hall_dn_led = dn_l;
  assign bus.car_led     = car_l;
  assign bus.floor       = floor_q;
  assign bus.direction   = dir_q;
  assign bus.door_open   = door_q;
  assign bus.moving      = moving_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Scoreboard bench for elevator_scan_ctrl: directed scenarios queue every
// expected output change with its cycle; a monitor pops and compares.
module tb_elevator_scan_ctrl;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  elevator_scan_ctrl_if #(.NUM_FLOORS(N), .FLOOR_W(2)) bus ();

  elevator_scan_ctrl #(
    .NUM_FLOORS(N), .FLOOR_W(2), .MOVE_CYCLES(8), .DOOR_CYCLES(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int          cyc;
    logic [17:0] v;
  } ev_t;

  ev_t q[$];
  int  cyc    = 0;
  int  errors = 0;
  int  checks = 0;

  logic [17:0] cur;
  assign cur = {bus.floor, bus.direction, bus.door_open, bus.moving,
                bus.hall_up_led, bus.hall_dn_led, bus.car_led};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [17:0] pk(input logic [1:0] fl, input logic [1:0] d,
                                     input logic dr, input logic mv,
                                     input logic [3:0] u, input logic [3:0] dn,
                                     input logic [3:0] c);
    return {fl, d, dr, mv, u, dn, c};
  endfunction

  task automatic want(input int k, input logic [1:0] fl, input logic [1:0] d,
                      input logic dr, input logic mv, input logic [3:0] u,
                      input logic [3:0] dn, input logic [3:0] c);
    ev_t e;
    e.cyc = k;
    e.v   = pk(fl, d, dr, mv, u, dn, c);
    q.push_back(e);
  endtask

  task automatic check_now(input string name, input logic [17:0] req);
    checks++;
    if (cur !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, cur, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start(output int t);
    tick();
    t = cyc;
  endtask

  task automatic pulse(input logic [3:0] c, input logic [3:0] u, input logic [3:0] d);
    bus.car_req     = c;
    bus.hall_up_req = u;
    bus.hall_dn_req = d;
    tick();
    bus.car_req     = '0;
    bus.hall_up_req = '0;
    bus.hall_dn_req = '0;
  endtask

  // Monitor: every change of any output is an event that must match the queue head.
  initial begin
    logic [17:0] prev;
    ev_t         e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev = cur;
      end else if (cur !== prev) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: cyc=%0d got %h required no change", cyc, cur);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.v !== cur) begin
            errors++;
            $display("FAIL event: got cyc=%0d val=%h required cyc=%0d val=%h",
                     cyc, cur, e.cyc, e.v);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    int t;
    bus.car_req     = '0;
    bus.hall_up_req = '0;
    bus.hall_dn_req = '0;
    bus.door_hold   = 1'b0;
    #2 rst = 1'b0;
    repeat (3) tick();
    check_now("reset_state", pk(2'd0, 2'b00, 0, 0, 4'h0, 4'h0, 4'h0));
    rst = 1'b1;
    repeat (2) tick();

    // Car call to floor 2 from idle at floor 0.
    start(t);
    want(t+1,  2'd0, 2'b00, 0, 0, 4'h0, 4'h0, 4'b0100);
    want(t+2,  2'd0, 2'b10, 0, 1, 4'h0, 4'h0, 4'b0100);
    want(t+10, 2'd1, 2'b10, 0, 1, 4'h0, 4'h0, 4'b0100);
    want(t+18, 2'd2, 2'b10, 1, 0, 4'h0, 4'h0, 4'b0000);
    want(t+23, 2'd2, 2'b00, 0, 0, 4'h0, 4'h0, 4'b0000);
    pulse(4'b0100, 4'h0, 4'h0);
    repeat (25) tick();

    // Door opened at floor 2, door_hold held 10 cycles.
    start(t);
    want(t+1,  2'd2, 2'b00, 0, 0, 4'h0, 4'h0, 4'b0100);
    want(t+2,  2'd2, 2'b00, 1, 0, 4'h0, 4'h0, 4'b0000);
    want(t+17, 2'd2, 2'b00, 0, 0, 4'h0, 4'h0, 4'b0000);
    pulse(4'b0100, 4'h0, 4'h0);
    tick();
    bus.door_hold = 1'b1;
    repeat (10) tick();
    bus.door_hold = 1'b0;
    repeat (8) tick();

    // Move down to floor 1.
    start(t);
    want(t+1,  2'd2, 2'b00, 0, 0, 4'h0, 4'h0, 4'b0010);
    want(t+2,  2'd2, 2'b01, 0, 1, 4'h0, 4'h0, 4'b0010);
    want(t+10, 2'd1, 2'b01, 1, 0, 4'h0, 4'h0, 4'b0000);
    want(t+15, 2'd1, 2'b00, 0, 0, 4'h0, 4'h0, 4'b0000);
    pulse(4'b0010, 4'h0, 4'h0);
    repeat (17) tick();

    // Idle at 1, calls to 0 and 3 together: up first.
    start(t);
    want(t+1,  2'd1, 2'b00, 0, 0, 4'h0, 4'h0, 4'b1001);
    want(t+2,  2'd1, 2'b10, 0, 1, 4'h0, 4'h0, 4'b1001);
    want(t+10, 2'd2, 2'b10, 0, 1, 4'h0, 4'h0, 4'b1001);
    want(t+18, 2'd3, 2'b10, 1, 0, 4'h0, 4'h0, 4'b0001);
    want(t+23, 2'd3, 2'b01, 0, 1, 4'h0, 4'h0, 4'b0001);
    want(t+31, 2'd2, 2'b01, 0, 1, 4'h0, 4'h0, 4'b0001);
    want(t+39, 2'd1, 2'b01, 0, 1, 4'h0, 4'h0, 4'b0001);
    want(t+47, 2'd0, 2'b01, 1, 0, 4'h0, 4'h0, 4'b0000);
    want(t+52, 2'd0, 2'b00, 0, 0, 4'h0, 4'h0, 4'b0000);
    pulse(4'b1001, 4'h0, 4'h0);
    repeat (54) tick();

    // Car call to 3 with hall-up at 1 pressed on the way.
    start(t);
    want(t+1,  2'd0, 2'b00, 0, 0, 4'h0,    4'h0, 4'b1000);
    want(t+2,  2'd0, 2'b10, 0, 1, 4'h0,    4'h0, 4'b1000);
    want(t+5,  2'd0, 2'b10, 0, 1, 4'b0010, 4'h0, 4'b1000);
    want(t+10, 2'd1, 2'b10, 1, 0, 4'h0,    4'h0, 4'b1000);
    want(t+15, 2'd1, 2'b10, 0, 1, 4'h0,    4'h0, 4'b1000);
    want(t+23, 2'd2, 2'b10, 0, 1, 4'h0,    4'h0, 4'b1000);
    want(t+31, 2'd3, 2'b10, 1, 0, 4'h0,    4'h0, 4'b0000);
    want(t+36, 2'd3, 2'b00, 0, 0, 4'h0,    4'h0, 4'b0000);
    pulse(4'b1000, 4'h0, 4'h0);
    repeat (3) tick();
    pulse(4'h0, 4'b0010, 4'h0);
    repeat (34) tick();

    // Reset asserted while travelling between floors 2 and 1.
    start(t);
    want(t+1,  2'd3, 2'b00, 0, 0, 4'h0, 4'h0, 4'b0001);
    want(t+2,  2'd3, 2'b01, 0, 1, 4'h0, 4'h0, 4'b0001);
    want(t+10, 2'd2, 2'b01, 0, 1, 4'h0, 4'h0, 4'b0001);
    pulse(4'b0001, 4'h0, 4'h0);
    repeat (13) tick();
    #1 rst = 1'b0;
    #1 check_now("async_reset_mid_move", pk(2'd0, 2'b00, 0, 0, 4'h0, 4'h0, 4'h0));
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) tick();

    // Latched hall-down at 1 is passed going up, served on the way down.
    start(t);
    want(t+1,  2'd0, 2'b00, 0, 0, 4'h0, 4'b0010, 4'b1000);
    want(t+2,  2'd0, 2'b10, 0, 1, 4'h0, 4'b0010, 4'b1000);
    want(t+10, 2'd1, 2'b10, 0, 1, 4'h0, 4'b0010, 4'b1000);
    want(t+18, 2'd2, 2'b10, 0, 1, 4'h0, 4'b0010, 4'b1000);
    want(t+26, 2'd3, 2'b10, 1, 0, 4'h0, 4'b0010, 4'b0000);
    want(t+31, 2'd3, 2'b01, 0, 1, 4'h0, 4'b0010, 4'b0000);
    want(t+39, 2'd2, 2'b01, 0, 1, 4'h0, 4'b0010, 4'b0000);
    want(t+47, 2'd1, 2'b01, 1, 0, 4'h0, 4'b0000, 4'b0000);
    want(t+52, 2'd1, 2'b00, 0, 0, 4'h0, 4'b0000, 4'b0000);
    pulse(4'b1000, 4'h0, 4'b0010);
    repeat (54) tick();

    // Hall-up at the top and hall-down at the bottom never latch.
    start(t);
    pulse(4'h0, 4'b1000, 4'b0001);
    repeat (3) tick();
    check_now("ignored_hall_bits", pk(2'd1, 2'b00, 0, 0, 4'h0, 4'h0, 4'h0));

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d left required 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
